// File: rtl/mic_array_pkg.sv
// Shared types and default sizing for the I2S MEMS mic array sequencer.
// Latency: none (declarations only).
// Backpressure: n/a.
package mic_array_pkg;

    localparam int DEF_BCLK_DIV      = 32;
    localparam int DEF_NUM_MICS      = 3;
    localparam int DEF_SLOT_BITS     = 32;
    localparam int DEF_MIC_WORD_BITS = 24;
    localparam int DEF_SAMPLE_BITS   = 16;

    localparam int DEF_CHAN_W = (DEF_NUM_MICS > 1) ? $clog2(DEF_NUM_MICS) : 1;

    typedef logic [DEF_CHAN_W-1:0] chan_t;

    typedef enum logic {
        OUT_IDLE,
        OUT_SEND
    } out_state_t;

endpackage

// File: rtl/i2s_clock_gen.sv
// I2S bit clock / word select generator driven by clock-enable counters.
// Latency: bclk/ws registered, valid the cycle after the counters move; strobes are combinational.
// Backpressure: none; free-running while enable_in is high, held at zero otherwise.
//
// Ports: clk_in/rst_in (async active-high), enable_in; bclk_out/ws_out to the mics;
// rise_out/fall_out one-cycle strobes marking the BCLK edges; bit_idx_out position in the frame.
module i2s_clock_gen #(
    parameter int BCLK_DIV  = 32,
    parameter int SLOT_BITS = 32
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           enable_in,
    output logic                           bclk_out,
    output logic                           ws_out,
    output logic                           rise_out,
    output logic                           fall_out,
    output logic [$clog2(2*SLOT_BITS)-1:0] bit_idx_out
);

    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam int BIT_W = $clog2(2*SLOT_BITS);

    logic [DIV_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             bclk_q, bclk_d;
    logic             ws_q, ws_d;
    logic             rise, fall;

    always_comb begin
        rise   = enable_in && (div_q == DIV_W'(BCLK_DIV/2));
        // fall marks the cycle whose clock edge wraps div back to 0
        fall   = enable_in && (div_q == DIV_W'(BCLK_DIV-1));
        div_d  = '0;
        bit_d  = '0;
        if (enable_in) begin
            div_d = fall ? '0 : div_q + 1'b1;
            bit_d = bit_q;
            if (fall) begin
                bit_d = (bit_q == BIT_W'(2*SLOT_BITS-1)) ? '0 : bit_q + 1'b1;
            end
        end
        // Registered from the next counter values so bclk/ws line up with div/bit_idx
        bclk_d = (div_d >= DIV_W'(BCLK_DIV/2));
        ws_d   = (bit_d >= BIT_W'(SLOT_BITS));
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            div_q  <= '0;
            bit_q  <= '0;
            bclk_q <= 1'b0;
            ws_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            bit_q  <= bit_d;
            bclk_q <= bclk_d;
            ws_q   <= ws_d;
        end
    end

    assign bclk_out    = bclk_q;
    assign ws_out      = ws_q;
    assign rise_out    = rise;
    assign fall_out    = fall;
    assign bit_idx_out = bit_q;

endmodule

// File: rtl/mic_array_sequencer.sv
// Captures the left-slot word of every I2S mic in parallel and streams truncated samples per channel.
// Latency: sample_valid_out rises 2 cycles after the rise strobe that captures the last data bit.
// Backpressure: valid/ready; data/chan held while !ready; a new frame overwrites undrained samples (overrun).
//
// Ports: clk_in/rst_in (async active-high); enable_in runs the I2S clocks; mic_mask_in selects output
// channels at frame latch; mic_data_in mic DOUT lines; bclk_out/ws_out to the mics; sample/chan/valid/ready
// stream; frame_start_out latch pulse; overrun_out sticky flag cleared by overrun_clr_in.
module mic_array_sequencer
    import mic_array_pkg::*;
#(
    parameter int BCLK_DIV      = DEF_BCLK_DIV,
    parameter int NUM_MICS      = DEF_NUM_MICS,
    parameter int SLOT_BITS     = DEF_SLOT_BITS,
    parameter int MIC_WORD_BITS = DEF_MIC_WORD_BITS,
    parameter int SAMPLE_BITS   = DEF_SAMPLE_BITS
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        enable_in,
    input  logic [NUM_MICS-1:0]         mic_mask_in,
    input  logic [NUM_MICS-1:0]         mic_data_in,
    output logic                        bclk_out,
    output logic                        ws_out,
    output logic [SAMPLE_BITS-1:0]      sample_out,
    output logic [$clog2(NUM_MICS)-1:0] chan_out,
    output logic                        sample_valid_out,
    input  logic                        sample_ready_in,
    output logic                        frame_start_out,
    output logic                        overrun_out,
    input  logic                        overrun_clr_in
);

    localparam int CHAN_W = $clog2(NUM_MICS);
    localparam int BIT_W  = $clog2(2*SLOT_BITS);
    localparam logic [NUM_MICS-1:0] ONE = NUM_MICS'(1);

    logic             rise, fall;
    logic [BIT_W-1:0] bit_idx;

    i2s_clock_gen #(
        .BCLK_DIV  (BCLK_DIV),
        .SLOT_BITS (SLOT_BITS)
    ) u_clk_gen (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .enable_in   (enable_in),
        .bclk_out    (bclk_out),
        .ws_out      (ws_out),
        .rise_out    (rise),
        .fall_out    (fall),
        .bit_idx_out (bit_idx)
    );

    logic [MIC_WORD_BITS-1:0] shift_q [NUM_MICS];
    logic [MIC_WORD_BITS-1:0] shift_d [NUM_MICS];
    logic [SAMPLE_BITS-1:0]   hold_q  [NUM_MICS];
    logic [SAMPLE_BITS-1:0]   hold_d  [NUM_MICS];
    logic [NUM_MICS-1:0]      pending_q, pending_d;
    logic                     stale_q, stale_d;
    logic                     frame_start_q, frame_start_d;
    logic                     overrun_q, overrun_d;

    out_state_t               state_q;
    logic                     valid_q;
    logic [SAMPLE_BITS-1:0]   sample_q;
    logic [CHAN_W-1:0]        chan_q;

    logic                     capture, frame_done, frame_wrap, hs, sent;
    logic [CHAN_W-1:0]        sel_idle, sel_next;

    function automatic logic [CHAN_W-1:0] lowest_set(input logic [NUM_MICS-1:0] m);
        logic [CHAN_W-1:0] r;
        r = '0;
        for (int i = NUM_MICS - 1; i >= 0; i--) begin
            if (m[i]) r = CHAN_W'(i);
        end
        return r;
    endfunction

    always_comb begin
        // I2S one-bit delay: MSB of the left word sits in bit slot 1
        capture    = rise && (bit_idx >= BIT_W'(1)) && (bit_idx <= BIT_W'(MIC_WORD_BITS));
        frame_done = rise && (bit_idx == BIT_W'(MIC_WORD_BITS));
        frame_wrap = fall && (bit_idx == BIT_W'(2*SLOT_BITS-1));
        hs         = valid_q && sample_ready_in;
        sent       = (state_q == OUT_SEND) && hs;

        for (int i = 0; i < NUM_MICS; i++) begin
            shift_d[i] = shift_q[i];
            if (!enable_in || frame_wrap) begin
                shift_d[i] = '0;
            end else if (capture) begin
                shift_d[i] = {shift_q[i][MIC_WORD_BITS-2:0], mic_data_in[i]};
            end
            // shift_d already holds the final bit on the frame_done cycle
            hold_d[i] = frame_done ? shift_d[i][MIC_WORD_BITS-1 -: SAMPLE_BITS] : hold_q[i];
        end

        pending_d = pending_q;
        stale_d   = stale_q;
        if (sent) begin
            // A word from an overwritten frame does not retire a bit of the new frame
            if (!stale_q) pending_d = pending_q & ~(ONE << chan_q);
            stale_d = 1'b0;
        end
        if (frame_done) begin
            pending_d = mic_mask_in;
            stale_d   = (state_q == OUT_SEND) && !hs;
        end
        if (!enable_in && ((state_q == OUT_IDLE) || sent)) begin
            pending_d = '0;
            stale_d   = 1'b0;
        end

        frame_start_d = frame_done;
        if (frame_done && (pending_q != '0)) begin
            overrun_d = 1'b1;
        end else if (overrun_clr_in) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        sel_idle = lowest_set(pending_q);
        sel_next = lowest_set(pending_d);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_MICS; i++) begin
                shift_q[i] <= '0;
                hold_q[i]  <= '0;
            end
            pending_q     <= '0;
            stale_q       <= 1'b0;
            frame_start_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_MICS; i++) begin
                shift_q[i] <= shift_d[i];
                hold_q[i]  <= hold_d[i];
            end
            pending_q     <= pending_d;
            stale_q       <= stale_d;
            frame_start_q <= frame_start_d;
            overrun_q     <= overrun_d;
        end
    end

    // Output stream FSM; next word comes from the post-handshake pending set so
    // back-to-back channels go out without a bubble.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= OUT_IDLE;
            valid_q  <= 1'b0;
            sample_q <= '0;
            chan_q   <= '0;
        end else begin
            case (state_q)
                OUT_IDLE: begin
                    if (enable_in && (pending_q != '0)) begin
                        chan_q   <= sel_idle;
                        sample_q <= hold_q[sel_idle];
                        valid_q  <= 1'b1;
                        state_q  <= OUT_SEND;
                    end
                end
                OUT_SEND: begin
                    if (hs) begin
                        if (pending_d != '0) begin
                            chan_q   <= sel_next;
                            sample_q <= hold_d[sel_next];
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= OUT_IDLE;
                        end
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= OUT_IDLE;
                end
            endcase
        end
    end

    assign sample_out       = sample_q;
    assign chan_out         = chan_q;
    assign sample_valid_out = valid_q;
    assign frame_start_out  = frame_start_q;
    assign overrun_out      = overrun_q;

endmodule

// File: tb/tb_mic_array_sequencer.sv
// Scoreboard bench for mic_array_sequencer: directed frames, expected samples queued by stimulus.
// Latency: n/a.
// Backpressure: bench drives sample_ready_in patterns (always, toggling, long stalls).
module tb_mic_array_sequencer;
    import mic_array_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        enable_in;
    logic [2:0]  mic_mask_in;
    logic [2:0]  mic_data_in = '0;
    logic        bclk_out;
    logic        ws_out;
    logic [15:0] sample_out;
    logic [1:0]  chan_out;
    logic        sample_valid_out;
    logic        sample_ready_in;
    logic        frame_start_out;
    logic        overrun_out;
    logic        overrun_clr_in;

    always #5 clk_in = ~clk_in;

    mic_array_sequencer #(
        .BCLK_DIV      (32),
        .NUM_MICS      (3),
        .SLOT_BITS     (32),
        .MIC_WORD_BITS (24),
        .SAMPLE_BITS   (16)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .enable_in        (enable_in),
        .mic_mask_in      (mic_mask_in),
        .mic_data_in      (mic_data_in),
        .bclk_out         (bclk_out),
        .ws_out           (ws_out),
        .sample_out       (sample_out),
        .chan_out         (chan_out),
        .sample_valid_out (sample_valid_out),
        .sample_ready_in  (sample_ready_in),
        .frame_start_out  (frame_start_out),
        .overrun_out      (overrun_out),
        .overrun_clr_in   (overrun_clr_in)
    );

    int checks = 0;
    int errors = 0;

    // Cycle number since enable rose (cycle 0 = first enabled cycle)
    int ecnt = 0;
    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in)          ecnt <= 0;
        else if (!enable_in) ecnt <= 0;
        else                 ecnt <= ecnt + 1;
    end

    // Mic model: left word MSB-first in bit slots 1..24, ones everywhere else
    logic [23:0] words [3];
    always begin : mic_model
        int b;
        @(posedge clk_in);
        #1;
        b = (ecnt / 32) % 64;
        for (int i = 0; i < 3; i++) begin
            mic_data_in[i] = (b >= 1 && b <= 24) ? words[i][24 - b] : 1'b1;
        end
    end

    typedef struct packed {
        chan_t       chan;
        logic [15:0] dat;
    } exp_t;
    exp_t exp_q[$];

    task automatic push(input logic [1:0] c, input logic [15:0] d);
        exp_t e;
        e.chan = c;
        e.dat  = d;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (ecnt=%0d)", name, act, req, ecnt);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic wait_ecnt(input int n);
        int budget;
        budget = 20000;
        while (ecnt != n && budget > 0) begin
            step(1);
            budget--;
        end
        if (budget == 0) chk("wait_ecnt_timeout", 32'(ecnt), 32'(n));
    endtask

    // Monitor: scoreboard pops on handshake, hold stability, BCLK/WS timing
    int          hs_count   = 0;
    int          last_hs    = -1;
    int          last_rise  = -1;
    int          fs_count   = 0;
    int          last_fs    = -1;
    logic        prev_hold  = 1'b0;
    logic        prev_vld   = 1'b0;
    logic [15:0] prev_dat   = '0;
    logic [1:0]  prev_chan  = '0;
    exp_t        e_mon;
    logic        exp_b, exp_w;

    always @(negedge clk_in) begin
        if (rst_in) begin
            prev_hold = 1'b0;
            prev_vld  = 1'b0;
        end else begin
            if (prev_hold) begin
                checks++;
                if (!sample_valid_out || sample_out !== prev_dat || chan_out !== prev_chan) begin
                    errors++;
                    $display("FAIL hold_stable: got vld=%0b ch=%0d dat=%h expected vld=1 ch=%0d dat=%h",
                             sample_valid_out, chan_out, sample_out, prev_chan, prev_dat);
                end
            end
            if (sample_valid_out && !prev_vld) last_rise = ecnt;
            if (sample_valid_out && sample_ready_in) begin
                hs_count++;
                last_hs = ecnt;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_sample: got ch=%0d dat=%h expected none", chan_out, sample_out);
                end else begin
                    e_mon = exp_q.pop_front();
                    if (chan_out !== e_mon.chan || sample_out !== e_mon.dat) begin
                        errors++;
                        $display("FAIL sample: got ch=%0d dat=%h expected ch=%0d dat=%h",
                                 chan_out, sample_out, e_mon.chan, e_mon.dat);
                    end
                end
            end
            if (frame_start_out) begin
                fs_count++;
                last_fs = ecnt;
            end
            if ((ecnt % 32) == 0 || (ecnt % 32) == 15 || (ecnt % 32) == 16 || (ecnt % 32) == 31) begin
                exp_b = ((ecnt % 32) >= 16);
                exp_w = (((ecnt / 32) % 64) >= 32);
                checks++;
                if (bclk_out !== exp_b || ws_out !== exp_w) begin
                    errors++;
                    $display("FAIL bclk_ws: got bclk=%0b ws=%0b expected bclk=%0b ws=%0b (ecnt=%0d)",
                             bclk_out, ws_out, exp_b, exp_w, ecnt);
                end
            end
            prev_hold = sample_valid_out && !sample_ready_in;
            prev_vld  = sample_valid_out;
            prev_dat  = sample_out;
            prev_chan = chan_out;
        end
    end

    int hs0, fs0;

    initial begin
        rst_in          = 1'b1;
        enable_in       = 1'b0;
        mic_mask_in     = 3'b000;
        sample_ready_in = 1'b0;
        overrun_clr_in  = 1'b0;
        for (int i = 0; i < 3; i++) words[i] = '0;

        #2;
        chk("rst_valid",   32'(sample_valid_out), 32'h0);
        chk("rst_sample",  32'(sample_out),       32'h0);
        chk("rst_chan",    32'(chan_out),         32'h0);
        chk("rst_bclk",    32'(bclk_out),         32'h0);
        chk("rst_ws",      32'(ws_out),           32'h0);
        chk("rst_fstart",  32'(frame_start_out),  32'h0);
        chk("rst_overrun", 32'(overrun_out),      32'h0);
        step(3);
        rst_in = 1'b0;
        step(2);

        // Frame 0: all channels, ready always high
        words[0] = 24'h123456; words[1] = 24'hFEDCBA; words[2] = 24'h00FF00;
        mic_mask_in = 3'b111;
        sample_ready_in = 1'b1;
        push(2'd0, 16'h1234); push(2'd1, 16'hFEDC); push(2'd2, 16'h00FF);
        hs0 = hs_count; fs0 = fs_count;
        enable_in = 1'b1;
        wait_ecnt(795);
        chk("first_valid_cycle", 32'(last_rise), 32'd786);
        chk("last_hs_cycle",     32'(last_hs),   32'd788);
        chk("hs_count_f0",       32'(hs_count - hs0), 32'd3);
        chk("fs_count_f0",       32'(fs_count - fs0), 32'd1);
        chk("fs_cycle_f0",       32'(last_fs),   32'd785);

        // Frame 1: mask 101, ready toggling
        wait_ecnt(800);
        words[0] = 24'h800001; words[1] = 24'h7FFFFF; words[2] = 24'hABCDEF;
        mic_mask_in = 3'b101;
        push(2'd0, 16'h8000); push(2'd2, 16'hABCD);
        hs0 = hs_count;
        wait_ecnt(2820);
        for (int k = 0; k < 40; k++) begin
            sample_ready_in = ~sample_ready_in;
            step(1);
        end
        sample_ready_in = 1'b1;
        wait_ecnt(2870);
        chk("hs_count_f1", 32'(hs_count - hs0), 32'd2);
        chk("queue_empty_f1", 32'(exp_q.size()), 32'd0);

        // Frames 2/3: long stall produces overrun
        wait_ecnt(2900);
        sample_ready_in = 1'b0;
        words[0] = 24'h111111; words[1] = 24'h222222; words[2] = 24'h333333;
        mic_mask_in = 3'b111;
        push(2'd0, 16'h1111);
        wait_ecnt(5000);
        words[0] = 24'h444444; words[1] = 24'h555555; words[2] = 24'h666666;
        push(2'd0, 16'h4444); push(2'd1, 16'h5555); push(2'd2, 16'h6666);
        wait_ecnt(6928);
        chk("overrun_before", 32'(overrun_out), 32'h0);
        chk("held_valid",     32'(sample_valid_out), 32'h1);
        chk("held_sample",    32'(sample_out), 32'h1111);
        step(1);
        chk("overrun_set",    32'(overrun_out), 32'h1);
        chk("fstart_f3",      32'(frame_start_out), 32'h1);
        chk("held_after_ovr", 32'(sample_out), 32'h1111);
        wait_ecnt(7000);
        sample_ready_in = 1'b1;
        wait_ecnt(7010);
        chk("queue_empty_f3", 32'(exp_q.size()), 32'd0);
        chk("overrun_sticky", 32'(overrun_out), 32'h1);
        overrun_clr_in = 1'b1;
        step(1);
        overrun_clr_in = 1'b0;
        chk("overrun_cleared", 32'(overrun_out), 32'h0);

        // Frame 4 held in flight, enable dropped during bit slot 10 of the next frame
        wait_ecnt(7020);
        sample_ready_in = 1'b0;
        words[0] = 24'h0A0B0C; words[1] = 24'h0D0E0F; words[2] = 24'h102030;
        push(2'd0, 16'h0A0B);
        wait_ecnt(10579);
        chk("bclk_before_dis", 32'(bclk_out), 32'h1);
        chk("valid_before_dis", 32'(sample_valid_out), 32'h1);
        enable_in = 1'b0;
        step(1);
        chk("bclk_after_dis", 32'(bclk_out), 32'h0);
        chk("ws_after_dis",   32'(ws_out), 32'h0);
        step(4);
        sample_ready_in = 1'b1;
        step(40);
        chk("valid_after_drain", 32'(sample_valid_out), 32'h0);
        chk("queue_empty_dis",   32'(exp_q.size()), 32'd0);

        // Re-enable
        words[0] = 24'h7F0001; words[1] = 24'h80FFFF; words[2] = 24'h00007F;
        push(2'd0, 16'h7F00); push(2'd1, 16'h80FF); push(2'd2, 16'h0000);
        enable_in = 1'b1;
        wait_ecnt(795);
        chk("reenable_valid_cycle", 32'(last_rise), 32'd786);
        chk("queue_empty_reen", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of OUT_SEND
        sample_ready_in = 1'b0;
        wait_ecnt(2840);
        chk("valid_before_rst", 32'(sample_valid_out), 32'h1);
        rst_in = 1'b1;
        #1;
        chk("mid_rst_valid",  32'(sample_valid_out), 32'h0);
        chk("mid_rst_sample", 32'(sample_out), 32'h0);
        chk("mid_rst_chan",   32'(chan_out), 32'h0);
        chk("mid_rst_bclk",   32'(bclk_out), 32'h0);
        chk("mid_rst_ws",     32'(ws_out), 32'h0);
        step(2);
        rst_in = 1'b0;
        sample_ready_in = 1'b1;
        push(2'd0, 16'h7F00); push(2'd1, 16'h80FF); push(2'd2, 16'h0000);
        step(5);
        chk("idle_after_rst", 32'(sample_valid_out), 32'h0);
        wait_ecnt(795);
        chk("post_rst_valid_cycle", 32'(last_rise), 32'd786);
        chk("queue_empty_end", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mic_array_sequencer.md
Name: mic_array_sequencer

Overview:
Sequences a small I2S MEMS microphone array from the 98.3 MHz audio clock.
- Generates the shared bit clock (BCLK) and word select (WS) from clock-enable counters.
- Captures the left-slot word of every microphone in parallel and truncates each to 16 bits.
- Emits the samples one channel at a time over a valid/ready stream to downstream DSP or the display path.
- Replaces per-mic free-running divider logic at top level.

Parameters:
- BCLK_DIV, 32, audio_clk cycles per BCLK period; even, >= 4.
- NUM_MICS, 3, number of mic data lines.
- SLOT_BITS, 32, BCLK periods per WS half-frame.
- MIC_WORD_BITS, 24, valid data bits per mic word, MSB first.
- SAMPLE_BITS, 16, output sample width; <= MIC_WORD_BITS.

Ports:
- clk_in, input, 1, audio clock (98.3 MHz).
- rst_in, input, 1, asynchronous active-high reset.
- enable_in, input, 1, run BCLK/WS and capture.
- mic_mask_in, input, NUM_MICS, channel enables for output; sampled at frame latch.
- mic_data_in, input, NUM_MICS, mic DOUT lines (pre-synchronised at top).
- bclk_out, output, 1, I2S bit clock to mics.
- ws_out, output, 1, I2S word select to mics.
- sample_out, output, SAMPLE_BITS, two's-complement sample.
- chan_out, output, clog2(NUM_MICS), channel index of sample_out.
- sample_valid_out, output, 1, stream valid.
- sample_ready_in, input, 1, stream ready.
- frame_start_out, output, 1, one-cycle pulse when a new frame is latched.
- overrun_out, output, 1, sticky: a frame was latched before the previous one drained.
- overrun_clr_in, input, 1, clears overrun_out.

Behaviour:
- Reset (async): all outputs 0; counters 0; output FSM OUT_IDLE; pending mask 0.
- Divider div counts 0..BCLK_DIV-1 while enable_in=1.
  - bclk_out = (div >= BCLK_DIV/2).
  - rise strobe at div==BCLK_DIV/2; fall strobe at div wrap to 0.
- bit_idx counts 0..2*SLOT_BITS-1 and advances on each fall strobe, wrapping 63->0.
  - ws_out = 0 for bit_idx < SLOT_BITS, 1 otherwise.
- Capture: on the rise strobe with bit_idx in 1..MIC_WORD_BITS, each mic's shift register shifts in mic_data_in[i]. The MSB arrives at bit_idx 1, per I2S one-bit delay. The right slot is ignored.
- Frame done: on the rise strobe at bit_idx==MIC_WORD_BITS.
  - Next cycle: holding regs <= shift[MIC_WORD_BITS-1 -: SAMPLE_BITS] (truncate, no rounding); pending <= mic_mask_in; frame_start_out pulses.
- Output FSM:
  - OUT_IDLE: if pending != 0, select the lowest set bit, drive sample_out/chan_out, valid=1, go to OUT_SEND. This is registered, so valid rises 1 cycle after the latch cycle.
  - OUT_SEND: hold data/chan stable while valid && !ready.
    - On handshake, clear that pending bit.
    - If further bits remain, present the next lowest channel on the following cycle with no bubble (valid stays 1). Otherwise valid=0 and go to OUT_IDLE.
- Latency: sample_valid_out rises 2 cycles after the bit-24 rise strobe. With BCLK_DIV=32, that is cycle 786 after the enable edge (div=0, bit_idx=0 at cycle 0).
- Overrun: a frame latch while pending != 0 sets overrun_out.
  - The in-flight word is unchanged until its handshake.
  - Holding regs and pending are then overwritten with the new frame, and the scan restarts at the lowest bit of the new pending.
  - overrun_clr_in clears overrun_out; a simultaneous set wins.
- mic_mask_in==0: frames still latch and pulse frame_start_out; no stream output.
- enable_in deassert:
  - Next cycle: div, bit_idx and shift regs are 0; bclk_out=ws_out=0.
  - Any in-flight word completes its handshake, then pending is cleared and the FSM goes to OUT_IDLE.
  - Re-enable restarts at div=0, bit_idx=0.
- Reset mid-transfer: immediate drop of valid, no handshake completion.

Decomposition:
- Package mic_array_pkg: NUM_MICS default, SLOT_BITS, MIC_WORD_BITS, chan_t typedef, out_state_t enum {OUT_IDLE, OUT_SEND}.
- Sub-module i2s_clock_gen: divider plus bit counter; outputs bclk, ws, rise/fall strobes and bit_idx.
- Capture and output FSM stay in mic_array_sequencer.

Test Plan:
1. Enable with BCLK_DIV=32 -> bclk period 32 cycles, high on div 16..31; ws low 1024 cycles then high 1024; frame period 2048 cycles.
2. Mics drive 24-bit words 0x123456, 0xFEDCBA, 0x00FF00, mask=3'b111, ready=1 -> valid first at cycle 786; outputs (ch0,0x1234), (ch1,0xFEDC), (ch2,0x00FF) on consecutive cycles; one frame_start pulse.
3. mask=3'b101, ready toggling 0/1 each cycle -> only ch0 then ch2; sample_out/chan_out stable while valid && !ready.
4. ready=0 for 3000 cycles -> overrun_out=1 at the second latch; ch0 data of frame 1 held; after ready=1, ch0(frame1) then ch0..ch2 of frame 2; overrun_clr_in pulse -> 0.
5. Deassert enable_in during bit_idx 10 with a word in flight -> bclk/ws low next cycle; in-flight word completes on ready; no further valid; re-enable -> valid again at cycle 786.
6. Assert rst_in mid-OUT_SEND -> all outputs 0 in the same cycle, no clock edge needed; FSM OUT_IDLE after release.
